// File: rtl/cordic_cmd_framer.sv
// Byte-stream framer: SYNC, mode, op[31:24..7:0] -> 48-bit word in a FIFO read by cordic_mode_controller.
// Word is queued on the last byte's edge; s_ready drops only on that last byte while the FIFO is full.
module cordic_cmd_framer #(
  parameter int         DEPTH       = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] MAX_MODE    = 8'd8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     RD_en,
  output logic [47:0]              Cor_in_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_err,
  output logic [15:0]              err_count
);

  typedef struct packed {
    logic [7:0]  pad;
    logic [7:0]  mode;
    logic [31:0] operand;
  } cmd_t;

  typedef enum logic [2:0] {HUNT, MODE, OP0, OP1, OP2, OP3} state_t;

  localparam int            AW       = $clog2(DEPTH);
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    mode_q, mode_d;
  logic [23:0]   op_q, op_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          acc_vld, stall, push_vld, bad_frame, tmo_hit, err_vld;
  cmd_t          push_dat;

  // Parser: next state, field capture and idle-timeout tracking.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    op_d      = op_q;
    tmo_d     = tmo_q;
    push_vld  = 1'b0;
    bad_frame = 1'b0;
    tmo_hit   = 1'b0;
    stall     = (state_q == OP3) && full;
    s_ready   = !stall;
    acc_vld   = s_valid && !stall;

    // Stalled cycles leave the counter untouched so backpressure never aborts a frame.
    if (state_q != HUNT) begin
      if (acc_vld) begin
        tmo_d = '0;
      end else if (!stall) begin
        if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          tmo_d   = '0;
          state_d = HUNT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end

    if (acc_vld) begin
      case (state_q)
        HUNT: if (s_data == SYNC_BYTE) state_d = MODE;
        MODE: begin
          mode_d  = s_data;
          state_d = OP0;
        end
        OP0: begin
          op_d    = {op_q[15:0], s_data};
          state_d = OP1;
        end
        OP1: begin
          op_d    = {op_q[15:0], s_data};
          state_d = OP2;
        end
        OP2: begin
          op_d    = {op_q[15:0], s_data};
          state_d = OP3;
        end
        OP3: begin
          state_d = HUNT;
          if (mode_q != 8'd0 && mode_q <= MAX_MODE) push_vld  = 1'b1;
          else                                      bad_frame = 1'b1;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign err_vld  = bad_frame || tmo_hit;
  assign push_dat = '{pad: 8'h00, mode: mode_q, operand: {op_q, s_data}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      mode_q    <= '0;
      op_q      <= '0;
      tmo_q     <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      frame_err <= err_vld;
      if (err_vld && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
    end
  end

  // Command FIFO; the head is copied into Cor_in_data only on a real pop.
  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_d;
  logic          do_push, do_pop;

  assign do_push = push_vld && !full;
  assign do_pop  = RD_en && !empty;

  always_comb begin
    level_d = fifo_level;
    case ({do_push, do_pop})
      2'b10:   level_d = fifo_level + 1'b1;
      2'b01:   level_d = fifo_level - 1'b1;
      default: level_d = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      Cor_in_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        Cor_in_data <= mem[rd_ptr];
      end
      fifo_level <= level_d;
      empty      <= (level_d == '0);
      full       <= (level_d == FULL_LVL);
    end
  end

endmodule

// File: doc/cordic_cmd_framer.md
Name: cordic_cmd_framer

Overview:
- Upstream command stage for cordic_mode_controller.
- Accepts a host byte stream through a valid/ready handshake and parses fixed 6-byte command frames.
- Each valid frame becomes one 48-bit command word, which is buffered in an internal FIFO.
- Presents the controller-side read interface: Cor_in_data, empty and RD_en.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, at least 2.
- SYNC_BYTE, 8'hA5: frame header value.
- TIMEOUT_CYC, 1024: maximum idle cycles between bytes inside a frame before the frame is aborted.
- MAX_MODE, 8: highest legal mode code.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_data  in  8  host byte.
- s_valid  in  1  host byte valid.
- s_ready  out  1  framer accepts the byte; a byte transfers when s_valid and s_ready are both high on an edge.
- RD_en  in  1  controller read strobe, one-cycle pulse.
- Cor_in_data  out  48  FIFO head word, registered: {8'h00, mode[7:0], operand[31:0]}.
- empty  out  1  FIFO holds no words.
- full  out  1  FIFO holds DEPTH words.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- err_count  out  16  dropped-frame counter; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=HUNT, FIFO pointers 0.
  - Cor_in_data=0, empty=1, full=0, fifo_level=0.
  - frame_err=0, err_count=0, s_ready=1, timeout counter=0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Frame layout, in byte order: SYNC_BYTE, mode, op[31:24], op[23:16], op[15:8], op[7:0]. The operand is big-endian.
- Parser states: HUNT, MODE, OP0, OP1, OP2, OP3.
  - HUNT: an accepted byte equal to SYNC_BYTE moves to MODE; any other byte is discarded silently, with no error.
  - MODE: the byte is latched as mode, then go to OP0.
  - OP0..OP2: the byte is shifted into the operand register (MSB first), then advance one state.
  - OP3: the final byte is combined with the latched fields into the word; the state returns to HUNT.
    - If mode is in 1..MAX_MODE, the word is pushed on the same edge.
    - If mode is 0 or greater than MAX_MODE, the word is not pushed; frame_err pulses and err_count increments.
- s_ready is low only in state OP3 while full=1, so the last byte waits until space exists. A frame is never partially lost to overflow.
- Timeout:
  - In any state other than HUNT, the counter increments on each cycle with no accepted byte and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYC, the parser returns to HUNT, frame_err pulses, err_count increments, and the counter clears.
  - Cycles spent stalled in OP3 because the FIFO is full do not count (the counter holds).
- FIFO: circular buffer; pointers wrap modulo DEPTH; fifo_level = writes − reads.
- Read rule: RD_en with empty=0 pops the head. Cor_in_data is loaded with the popped word on that edge and then holds until the next valid pop.
  - The controller samples two cycles after RD_en, so the data is stable from the cycle after RD_en onward.
  - RD_en while empty=1 is ignored: no pointer change, Cor_in_data is held.
- Simultaneous push and pop:
  - Both occur; fifo_level is unchanged.
  - When fifo_level=1, the pop returns the old head; the new word remains.
  - A pop when full=1 frees space; s_ready rises combinationally in the next cycle, not the same cycle.
- empty, full and fifo_level are registered and update on the edge of the push or pop.
- err_count saturates at 16'hFFFF; frame_err still pulses.

Test Plan:
- Single frame: send A5 01 3F 80 00 00, then pulse RD_en once empty=0.
  - Required: empty=0 one cycle after the last byte; Cor_in_data=48'h00_01_3F800000 the cycle after RD_en; empty=1 afterward.
- Resync: send 12 34 A5 08 00 00 00 10 A5 08 00 00 00 20, then read twice.
  - Required: words 48'h0008_00000010 and 48'h0008_00000020; frame_err never pulses.
- Bad mode: send A5 00 11 22 33 44, then A5 09 ....
  - Required: two frame_err pulses, err_count=2, empty stays 1.
- Overflow backpressure (DEPTH=16): send 17 frames with no reads.
  - Required: full=1 after 16 frames; s_ready=0 at the 17th frame's last byte.
  - After one RD_en, the 17th word enters; fifo_level=16; no data is lost or reordered.
- Timeout (TIMEOUT_CYC=1024): send A5 05 01, then idle 1024 cycles.
  - Required: frame_err pulses once, parser returns to HUNT, and a following complete frame is stored correctly.
- Edge cases:
  - RD_en while empty: Cor_in_data unchanged.
  - Push and pop on the same edge at level 1: level stays 1, FIFO order preserved.
  - reset_n asserted mid-frame: all outputs return to reset values immediately.
